fpm_pair_mult: RTL and testbench
================================

# fpm_pair_mult

Self-contained floating-point batch multiplier. It reads eight IEEE-754 single-precision constants from an internal 8-word ROM and multiplies them pairwise: (0,1), (2,3), (4,5), (6,7). It writes the four products into an internal 4-word RAM, then raises `done`. After that, an external checker reads the RAM through a dedicated address port. The block contains the ROM, the RAM, a multi-cycle FP multiplier and a sequencing FSM.

## Interface
- No parameters. ROM contents are fixed:
  - word 0 = 0x15350076, word 1 = 0x5952599F
  - word 2 = 0x3F800000, word 3 = 0x3E800000
  - word 4 = 0x40400000, word 5 = 0x41200000
  - word 6 = 0x3EA00000, word 7 = 0x3F600000
- Ports:
  - `clk`  in  1  single clock; all state changes on the rising edge.
  - `rst`  in  1  reset, asynchronous, active-low.
  - `ram_addr_juiz`  in  2  checker read address.
  - `ram_out_juiz`  out  32  RAM word at `ram_addr_juiz`.
  - `done`  out  1  high once all four products are stored.

## Operation
- Sequencer FSM states: LOAD_A, LOAD_B, WAIT_MUL, STORE, DONE.
  - On reset: state = LOAD_A, pair index k = 0.
- LOAD_A: latch ROM[2k] into multiplier operand A and assert mul_en. Next state LOAD_B.
- LOAD_B: latch ROM[2k+1] into operand B. Next state WAIT_MUL.
- WAIT_MUL: hold until the multiplier reports done.
- STORE: write the product to RAM[k] and drop mul_en.
  - If k == 3, go to DONE.
  - Otherwise k = k+1, pulse a one-cycle synchronous reset to the multiplier, and go to LOAD_A.
- DONE: terminal state, left only by `rst`.
  - `done` = 1.
  - RAM write is disabled.
  - RAM address mux selects `ram_addr_juiz`.
- Multiplier FSM states: GET_A, GET_B, UNPACK, SPECIAL, NORM_A, NORM_B, MUL0, MUL1, NORM1, NORM2, ROUND, PACK, PUT_Z.
  - Exponents are unbiased, 10-bit signed.
  - Mantissas are 24-bit with the hidden bit.
  - MUL0 forms the 48-bit product and sets z_e = a_e + b_e + 1.
  - MUL1 sets: z_m = product[47:24], guard = product[23], round_bit = product[22], sticky = OR(product[21:0]).
  - NORM1: left-shift while z_m[23] == 0, decrementing z_e each shift.
  - NORM2: right-shift while z_e < -126, OR-ing bits shifted out into sticky.
  - ROUND: round to nearest, ties to even. Carry out of 24'hFFFFFF increments z_e.
  - PACK: overflow (z_e > 127) produces ±Inf.
- Special cases, resolved in SPECIAL:
  - NaN input → 0xFFC00000.
  - Inf × 0 → 0xFFC00000.
  - Inf × finite → signed Inf.
  - 0 × finite → signed zero.
- Result sign = sign(A) XOR sign(B) in all non-NaN cases.
- RAM:
  - Reset clears all 4 words to 0.
  - `ram_out_juiz` = RAM[`ram_addr_juiz`] combinationally when `done` = 1; 32'h0 otherwise.

## Timing
- Reset values: `done` = 0, `ram_out_juiz` = 0, RAM = 0, multiplier output = 0, multiplier done = 0.
- Multiplier latency is 13 cycles from GET_A to PUT_Z for normal operands, plus one cycle per normalisation shift.
- Full run for the fixed ROM completes in under 100 cycles after reset release.
- `done` is registered and rises on the cycle after the last STORE.
- `ram_out_juiz` tracks `ram_addr_juiz` with zero cycles of latency once `done` = 1.
- Reset asserted mid-run has immediate effect:
  - aborts the run;
  - clears the RAM and `done`;
  - restarts from pair 0 on release.

## Configuration
- Macro: `FPM_SUBNORMAL_EN`.
- Defined: full gradual-underflow support.
  - Subnormal inputs are normalised in NORM_A/NORM_B, with exponent -126.
  - Results below the normal range are denormalised in NORM2 and packed with exponent field 0.
- Undefined:
  - Subnormal inputs are treated as zero (signed).
  - Results with z_e < -126 are flushed to signed zero.
  - The NORM2 shift loop is omitted.

## Test plan
- Reset held 5 cycles, then released → `done` = 0 and `ram_out_juiz` = 0 during the run; `done` = 1 within 100 cycles.
- After `done`, read addresses 1, 2, 3 → 0x3E800000 (1.0×0.25), 0x41F00000 (3.0×10.0), 0x3E8C0000 (0.3125×0.875).
- After `done`, read address 0 → matches a bit-exact round-to-nearest-even model of 0x15350076 × 0x5952599F.
- After `done`, sweep `ram_addr_juiz` 0→3 with one value per cycle → output changes within the same cycle and `done` stays 1.
- Assert `rst` while in WAIT_MUL of pair 2 → `done` = 0 and all RAM words = 0 immediately; after release, the run restarts and produces identical results.
- Directed multiplier check with A=0x7F800000, B=0 → 0xFFC00000. With the macro defined, A=0x00400000, B=0x3F800000 → 0x00400000; without it → 0x00000000.

Source files
------------

// File: rtl/fpm_pair_mult.sv
// fpm_pair_mult: batch IEEE-754 single-precision multiplier.
// Four pairs of ROM constants are multiplied in turn and the products are
// stored in a 4-word RAM. The RAM is then readable through ram_addr_juiz.
// Optional feature macro: FPM_SUBNORMAL_EN (gradual underflow). When it is
// not defined, subnormal inputs and results are flushed to signed zero.
`timescale 1ns/1ps

// Multi-cycle FP multiplier. Operand handshake: the caller holds a and b
// stable and raises en. The multiplier takes a in GET_A and b in GET_B, then
// raises z_done with z valid in PUT_Z. It stays there until srst returns it
// to GET_A.
module fpm_mult (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        srst,
    input  logic        en,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] z,
    output logic        z_done
);

    typedef enum logic [3:0] {
        GET_A = 4'd0, GET_B, UNPACK, SPECIAL, NORM_A, NORM_B,
        MUL0, MUL1, NORM1, NORM2, ROUND, PACK, PUT_Z
    } mul_state_t;

    // Exponents are unbiased two's complement values, 10 bits wide.
    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic        z_s;
        logic [9:0]  a_e;
        logic [9:0]  b_e;
        logic [9:0]  z_e;
        logic [23:0] a_m;
        logic [23:0] b_m;
        logic [23:0] z_m;
        logic [47:0] prod;
        logic        guard;
        logic        rnd;
        logic        sticky;
        logic [31:0] z;
        logic        z_done;
    } mul_dp_t;

    localparam logic signed [9:0] E_MIN  = -10'sd126;
    localparam logic signed [9:0] E_MAX  = 10'sd127;
    localparam logic signed [9:0] E_SPEC = 10'sd128;
    localparam logic signed [9:0] E_SUB  = -10'sd127;
    localparam logic [31:0]       QNAN   = 32'hFFC00000;

    mul_state_t state, state_n;
    mul_dp_t    dp, dp_n;

    logic a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;

    assign a_nan = (dp.a_e == E_SPEC) && (dp.a_m != 24'd0);
    assign b_nan = (dp.b_e == E_SPEC) && (dp.b_m != 24'd0);
    assign a_inf = (dp.a_e == E_SPEC) && (dp.a_m == 24'd0);
    assign b_inf = (dp.b_e == E_SPEC) && (dp.b_m == 24'd0);
`ifdef FPM_SUBNORMAL_EN
    assign a_zero = (dp.a_e == E_SUB) && (dp.a_m == 24'd0);
    assign b_zero = (dp.b_e == E_SUB) && (dp.b_m == 24'd0);
`else
    // Subnormal encodings count as zero in flush-to-zero builds.
    assign a_zero = (dp.a_e == E_SUB);
    assign b_zero = (dp.b_e == E_SUB);
`endif

    assign z      = dp.z;
    assign z_done = dp.z_done;

    // State and datapath registers; srst returns to the idle GET_A state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= GET_A;
            dp    <= '0;
        end else if (srst) begin
            state <= GET_A;
            dp    <= '0;
        end else begin
            state <= state_n;
            dp    <= dp_n;
        end
    end

    // Next-state and datapath update for each multiplier step.
    always_comb begin
        state_n = state;
        dp_n    = dp;
        case (state)
            GET_A: begin
                if (en) begin
                    dp_n.a  = a;
                    state_n = GET_B;
                end
            end
            GET_B: begin
                dp_n.b  = b;
                state_n = UNPACK;
            end
            UNPACK: begin
                dp_n.a_m = {1'b0, dp.a[22:0]};
                dp_n.b_m = {1'b0, dp.b[22:0]};
                dp_n.a_e = {2'b00, dp.a[30:23]} - 10'd127;
                dp_n.b_e = {2'b00, dp.b[30:23]} - 10'd127;
                dp_n.z_s = dp.a[31] ^ dp.b[31];
                state_n  = SPECIAL;
            end
            SPECIAL: begin
                if (a_nan || b_nan) begin
                    dp_n.z      = QNAN;
                    dp_n.z_done = 1'b1;
                    state_n     = PUT_Z;
                end else if (a_inf || b_inf) begin
                    dp_n.z      = (a_zero || b_zero) ? QNAN : {dp.z_s, 8'hFF, 23'd0};
                    dp_n.z_done = 1'b1;
                    state_n     = PUT_Z;
                end else if (a_zero || b_zero) begin
                    dp_n.z      = {dp.z_s, 31'd0};
                    dp_n.z_done = 1'b1;
                    state_n     = PUT_Z;
                end else begin
                    // Subnormals keep a zero hidden bit at the minimum exponent.
                    if (dp.a_e == E_SUB) dp_n.a_e = E_MIN;
                    else                 dp_n.a_m[23] = 1'b1;
                    if (dp.b_e == E_SUB) dp_n.b_e = E_MIN;
                    else                 dp_n.b_m[23] = 1'b1;
                    state_n = NORM_A;
                end
            end
            NORM_A: begin
                if (!dp.a_m[23]) begin
                    dp_n.a_m = {dp.a_m[22:0], 1'b0};
                    dp_n.a_e = dp.a_e - 10'd1;
                end else begin
                    state_n = NORM_B;
                end
            end
            NORM_B: begin
                if (!dp.b_m[23]) begin
                    dp_n.b_m = {dp.b_m[22:0], 1'b0};
                    dp_n.b_e = dp.b_e - 10'd1;
                end else begin
                    state_n = MUL0;
                end
            end
            MUL0: begin
                dp_n.prod = {24'd0, dp.a_m} * {24'd0, dp.b_m};
                dp_n.z_e  = dp.a_e + dp.b_e + 10'd1;
                state_n   = MUL1;
            end
            MUL1: begin
                dp_n.z_m    = dp.prod[47:24];
                dp_n.guard  = dp.prod[23];
                dp_n.rnd    = dp.prod[22];
                dp_n.sticky = |dp.prod[21:0];
                state_n     = NORM1;
            end
            NORM1: begin
                if (!dp.z_m[23]) begin
                    dp_n.z_m   = {dp.z_m[22:0], dp.guard};
                    dp_n.guard = dp.rnd;
                    dp_n.rnd   = 1'b0;
                    dp_n.z_e   = dp.z_e - 10'd1;
                end else begin
                    state_n = NORM2;
                end
            end
            NORM2: begin
`ifdef FPM_SUBNORMAL_EN
                // Denormalise until the exponent reaches the normal minimum.
                if ($signed(dp.z_e) < E_MIN) begin
                    dp_n.z_e    = dp.z_e + 10'd1;
                    dp_n.z_m    = {1'b0, dp.z_m[23:1]};
                    dp_n.guard  = dp.z_m[0];
                    dp_n.rnd    = dp.guard;
                    dp_n.sticky = dp.sticky | dp.rnd;
                end else begin
                    state_n = ROUND;
                end
`else
                state_n = ROUND;
`endif
            end
            ROUND: begin
                if (dp.guard && (dp.rnd || dp.sticky || dp.z_m[0])) begin
                    dp_n.z_m = dp.z_m + 24'd1;
                    if (dp.z_m == 24'hFFFFFF) dp_n.z_e = dp.z_e + 10'd1;
                end
                state_n = PACK;
            end
            PACK: begin
                dp_n.z = {dp.z_s, dp.z_e[7:0] + 8'd127, dp.z_m[22:0]};
`ifdef FPM_SUBNORMAL_EN
                if ((dp.z_e == E_MIN) && !dp.z_m[23]) dp_n.z[30:23] = 8'd0;
`else
                if ($signed(dp.z_e) < E_MIN) dp_n.z = {dp.z_s, 31'd0};
`endif
                if ($signed(dp.z_e) > E_MAX) dp_n.z = {dp.z_s, 8'hFF, 23'd0};
                dp_n.z_done = 1'b1;
                state_n     = PUT_Z;
            end
            PUT_Z: begin
                state_n = PUT_Z;
            end
            default: begin
                state_n = GET_A;
            end
        endcase
    end

endmodule

// Sequencer, ROM and result RAM around the multiplier.
module fpm_pair_mult (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  ram_addr_juiz,
    output logic [31:0] ram_out_juiz,
    output logic        done
);

    typedef enum logic [2:0] {
        LOAD_A   = 3'd0,
        LOAD_B   = 3'd1,
        WAIT_MUL = 3'd2,
        STORE    = 3'd3,
        DONE     = 3'd4
    } seq_state_t;

    seq_state_t  seq_state, seq_state_n;
    logic [1:0]  k, k_n;
    logic [31:0] op_a, op_a_n, op_b, op_b_n;
    logic        mul_en, mul_en_n;
    logic        done_n;
    logic        ram_we;
    logic        mul_srst;
    logic [31:0] mul_z;
    logic        mul_done;
    logic [31:0] ram [4];

    function automatic logic [31:0] rom_word(input logic [2:0] idx);
        case (idx)
            3'd0:    return 32'h15350076;
            3'd1:    return 32'h5952599F;
            3'd2:    return 32'h3F800000;
            3'd3:    return 32'h3E800000;
            3'd4:    return 32'h40400000;
            3'd5:    return 32'h41200000;
            3'd6:    return 32'h3EA00000;
            default: return 32'h3F600000;
        endcase
    endfunction

    fpm_mult u_mult (
        .clk    (clk),
        .rst_n  (rst),
        .srst   (mul_srst),
        .en     (mul_en),
        .a      (op_a),
        .b      (op_b),
        .z      (mul_z),
        .z_done (mul_done)
    );

    // Sequencer registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            seq_state <= LOAD_A;
            k         <= 2'd0;
            op_a      <= 32'd0;
            op_b      <= 32'd0;
            mul_en    <= 1'b0;
            done      <= 1'b0;
        end else begin
            seq_state <= seq_state_n;
            k         <= k_n;
            op_a      <= op_a_n;
            op_b      <= op_b_n;
            mul_en    <= mul_en_n;
            done      <= done_n;
        end
    end

    // Sequencer next state: load a pair, wait for the product, store it.
    always_comb begin
        seq_state_n = seq_state;
        k_n         = k;
        op_a_n      = op_a;
        op_b_n      = op_b;
        mul_en_n    = mul_en;
        done_n      = done;
        ram_we      = 1'b0;
        mul_srst    = 1'b0;
        case (seq_state)
            LOAD_A: begin
                op_a_n      = rom_word({k, 1'b0});
                mul_en_n    = 1'b1;
                seq_state_n = LOAD_B;
            end
            LOAD_B: begin
                op_b_n      = rom_word({k, 1'b1});
                seq_state_n = WAIT_MUL;
            end
            WAIT_MUL: begin
                if (mul_done) seq_state_n = STORE;
            end
            STORE: begin
                ram_we   = 1'b1;
                mul_en_n = 1'b0;
                if (k == 2'd3) begin
                    done_n      = 1'b1;
                    seq_state_n = DONE;
                end else begin
                    k_n         = k + 2'd1;
                    mul_srst    = 1'b1;
                    seq_state_n = LOAD_A;
                end
            end
            DONE: begin
                done_n = 1'b1;
            end
            default: begin
                seq_state_n = LOAD_A;
            end
        endcase
    end

    // Result RAM; written only from STORE, cleared by reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 4; i++) ram[i] <= 32'd0;
        end else if (ram_we && (seq_state != DONE)) begin
            ram[k] <= mul_z;
        end
    end

    assign ram_out_juiz = done ? ram[ram_addr_juiz] : 32'h0;

endmodule

// File: tb/tb_fpm_pair_mult.sv
// Bench for fpm_pair_mult: full batch run, readback, mid-run reset and
// directed checks on the multiplier submodule.
`timescale 1ns/1ps
module tb_fpm_pair_mult;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  ram_addr_juiz;
    logic [31:0] ram_out_juiz;
    logic        done;

    logic        t_srst;
    logic        t_en;
    logic [31:0] t_a;
    logic [31:0] t_b;
    logic [31:0] t_z;
    logic        t_done;

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_ram [4];

    always #5 clk = ~clk;

    fpm_pair_mult dut (
        .clk           (clk),
        .rst           (rst),
        .ram_addr_juiz (ram_addr_juiz),
        .ram_out_juiz  (ram_out_juiz),
        .done          (done)
    );

    fpm_mult u_mul (
        .clk    (clk),
        .rst_n  (rst),
        .srst   (t_srst),
        .en     (t_en),
        .a      (t_a),
        .b      (t_b),
        .z      (t_z),
        .z_done (t_done)
    );

    // Round-to-nearest-even reference for normal operands with a normal result.
    function automatic logic [31:0] model_mul_normal(input logic [31:0] a, input logic [31:0] b);
        logic [47:0] prod;
        logic [47:0] rem;
        logic [47:0] half;
        logic [47:0] sh_prod;
        logic [24:0] mant;
        int e;
        int sh;
        prod = {24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, b[22:0]};
        e = int'(a[30:23]) + int'(b[30:23]) - 127;
        if (prod[47]) begin
            sh = 24;
            e = e + 1;
        end else begin
            sh = 23;
        end
        sh_prod = prod >> sh;
        mant = sh_prod[24:0];
        rem = prod & ((48'd1 << sh) - 48'd1);
        half = 48'd1 << (sh - 1);
        if ((rem > half) || ((rem == half) && mant[0])) mant = mant + 25'd1;
        if (mant[24]) begin
            mant = mant >> 1;
            e = e + 1;
        end
        return {a[31] ^ b[31], 8'(e), mant[22:0]};
    endfunction

    task automatic wait_done(output logic ok, output int cycles);
        ok = 1'b0;
        cycles = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            cycles = i + 1;
            if (done) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic run_mul(input logic [31:0] a, input logic [31:0] b,
                           output logic [31:0] z, output logic ok);
        @(negedge clk);
        t_srst = 1'b1;
        t_en = 1'b0;
        @(negedge clk);
        t_srst = 1'b0;
        t_a = a;
        t_b = b;
        t_en = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (t_done) begin
                ok = 1'b1;
                break;
            end
        end
        z = t_z;
        t_en = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b0;
        ram_addr_juiz = 2'd0;
        repeat (5) @(negedge clk);
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL reset_done got %b want 0", done);
        end
        checks++;
        if (ram_out_juiz !== 32'h0) begin
            errors++;
            $display("FAIL reset_ram_out got %h want 00000000", ram_out_juiz);
        end
        checks++;
        if (dut.mul_z !== 32'h0 || dut.mul_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_mul got z=%h done=%b want 0/0", dut.mul_z, dut.mul_done);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (dut.ram[i] !== 32'h0) begin
                errors++;
                $display("FAIL reset_ram%0d got %h want 00000000", i, dut.ram[i]);
            end
        end
    endtask

    task automatic test_run;
        logic ok;
        int cyc;
        ok = 1'b0;
        cyc = 0;
        rst = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            ram_addr_juiz = 2'(i);
            #1;
            cyc = i + 1;
            if (done) begin
                ok = 1'b1;
                break;
            end
            checks++;
            if (ram_out_juiz !== 32'h0) begin
                errors++;
                $display("FAIL run_ram_out_zero cycle %0d got %h want 00000000", i, ram_out_juiz);
            end
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL run_done_timeout got done=%b want 1 within 100 cycles", done);
        end
    endtask

    task automatic test_products(input string tag);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            ram_addr_juiz = 2'(i);
            #1;
            checks++;
            if (ram_out_juiz !== exp_ram[i]) begin
                errors++;
                $display("FAIL %s_addr%0d got %h want %h", tag, i, ram_out_juiz, exp_ram[i]);
            end
        end
    endtask

    task automatic test_sweep;
        for (int i = 3; i >= 0; i--) begin
            @(negedge clk);
            ram_addr_juiz = 2'(3 - i);
            #1;
            checks++;
            if (ram_out_juiz !== exp_ram[3 - i] || done !== 1'b1) begin
                errors++;
                $display("FAIL sweep_addr%0d got %h done=%b want %h done=1",
                         3 - i, ram_out_juiz, done, exp_ram[3 - i]);
            end
        end
    endtask

    task automatic test_mid_reset;
        logic ok;
        int cyc;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (dut.seq_state == 3'd2 && dut.k == 2'd2) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL midrst_reach_pair2 got state=%0d pair=%0d want 2/2",
                     dut.seq_state, dut.k);
        end
        checks++;
        if (dut.ram[0] !== exp_ram[0] || dut.ram[1] !== exp_ram[1]) begin
            errors++;
            $display("FAIL midrst_partial got %h %h want %h %h",
                     dut.ram[0], dut.ram[1], exp_ram[0], exp_ram[1]);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (done !== 1'b0 || ram_out_juiz !== 32'h0) begin
            errors++;
            $display("FAIL midrst_outputs got done=%b out=%h want 0/00000000", done, ram_out_juiz);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (dut.ram[i] !== 32'h0) begin
                errors++;
                $display("FAIL midrst_ram%0d got %h want 00000000", i, dut.ram[i]);
            end
        end
        repeat (3) @(negedge clk);
        rst = 1'b1;
        wait_done(ok, cyc);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL midrst_rerun_timeout got done=%b want 1 after %0d cycles", done, cyc);
        end
    endtask

    task automatic test_mul_direct;
        logic [31:0] z;
        logic ok;
        logic [31:0] va [7];
        logic [31:0] vb [7];
        logic [31:0] vz [7];
        va[0] = 32'h7F800000; vb[0] = 32'h00000000; vz[0] = 32'hFFC00000;
        va[1] = 32'h7FC00000; vb[1] = 32'h3F800000; vz[1] = 32'hFFC00000;
        va[2] = 32'h7F800000; vb[2] = 32'hC0000000; vz[2] = 32'hFF800000;
        va[3] = 32'h80000000; vb[3] = 32'h3F800000; vz[3] = 32'h80000000;
        va[4] = 32'h7F000000; vb[4] = 32'h7F000000; vz[4] = 32'h7F800000;
        va[5] = 32'h3F800001; vb[5] = 32'h3FC00000; vz[5] = model_mul_normal(32'h3F800001, 32'h3FC00000);
        va[6] = 32'h00400000; vb[6] = 32'h3F800000;
`ifdef FPM_SUBNORMAL_EN
        vz[6] = 32'h00400000;
`else
        vz[6] = 32'h00000000;
`endif
        for (int i = 0; i < 7; i++) begin
            run_mul(va[i], vb[i], z, ok);
            checks++;
            if (!ok) begin
                errors++;
                $display("FAIL mul_timeout%0d got done=0 want done within 60 cycles", i);
            end else if (z !== vz[i]) begin
                errors++;
                $display("FAIL mul_vec%0d %h*%h got %h want %h", i, va[i], vb[i], z, vz[i]);
            end
        end
    endtask

    initial begin
        t_srst = 1'b0;
        t_en = 1'b0;
        t_a = 32'h0;
        t_b = 32'h0;
        exp_ram[0] = model_mul_normal(32'h15350076, 32'h5952599F);
        exp_ram[1] = 32'h3E800000;
        exp_ram[2] = 32'h41F00000;
        exp_ram[3] = 32'h3E8C0000;
        test_reset;
        test_run;
        test_products("run");
        test_sweep;
        test_mid_reset;
        test_products("rerun");
        test_mul_direct;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
